bus_ack_gen: RTL and testbench
==============================

Name: bus_ack_gen

Overview:
- Bus-slave acknowledge generator for memory-mapped slaves (scratch RAM, ROM, I/O).
- Sampling a request, it asserts an acknowledge after a programmable number of wait cycles; reads and writes have separate latencies.
- The acknowledge is held until the request drops.
- It also provides a reusable single-bit edge detector sub-module, used by slaves to spot the start of a new bus cycle (for example, to load a burst address counter).

Parameters:
- READ_STAGES, 3: wait cycles (0..15) before a read acknowledge.
- WRITE_STAGES, 0: wait cycles (0..15) before a write acknowledge.
- REGISTER_OUTPUT, 0: 1 = acknowledge passes through one extra output flop; 0 = combinational output.
- ID_WIDTH, 4: width of the transaction ID tags.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ce_i  in  1  clock enable; when low, all state holds.
- i  in  1  request active (cs & cyc & stb, qualified by the slave).
- we_i  in  1  write request; meaningful only while i=1.
- rid_i  in  ID_WIDTH  read transaction ID.
- wid_i  in  ID_WIDTH  write transaction ID.
- o  out  1  acknowledge.
- rid_o  out  ID_WIDTH  ID returned with a read acknowledge, else 0.
- wid_o  out  ID_WIDTH  ID returned with a write acknowledge, else 0.

Behaviour:
- Reset (async, rst_i=1):
  - cnt=0, id registers=0, output flop=0.
  - o, rid_o and wid_o read 0 while reset is held.
- Counter: 4-bit cnt, updated only when ce_i=1.
  - i=0: cnt<=0.
  - i=1: cnt<=cnt+1, saturating at 15.
- Request start (i=1 with cnt==0):
  - Latch rid_i into rid_q and wid_i into wid_q.
  - Latch we_i into we_q; the request type is fixed for the whole request.
- Request type: typ_w = we_i when cnt==0, else we_q.
- Raw acknowledge: ack_raw = i & (typ_w ? cnt>=WRITE_STAGES : cnt>=READ_STAGES).
  - With STAGES=0, ack_raw is combinational in the first request cycle.
- REGISTER_OUTPUT=0:
  - o = ack_raw.
  - rid_o = (ack_raw & ~typ_w) ? rid_q_or_rid_i : 0.
  - wid_o likewise for writes.
  - rid_q_or_rid_i means rid_i in the cnt==0 cycle, else rid_q.
- REGISTER_OUTPUT=1:
  - On ce_i: o <= ack_raw; rid_o and wid_o are registered the same way.
  - o therefore rises READ_STAGES+1 cycles after the first sampled request edge (WRITE_STAGES+1 for writes).
  - o falls one cycle after i drops.
- Acknowledge hold: o stays high for as long as i stays high. There is no single-cycle pulse mode.
- Request drop mid-wait: cnt clears and no acknowledge is issued. Re-assertion starts a fresh count.
- Back-to-back requests require i to go low for at least one ce cycle between them. Without that gap, the continuation is treated as the same request.
- ce_i=0: cnt, latches and the output flop hold. In combinational mode, o still tracks i through ack_raw.

Sub-module edge_det: ports rst, clk, ce, i, pe, ne, ee.
- State: one flop q, async reset to 0; q<=i when ce=1.
- pe = i & ~q (rising edge).
- ne = ~i & q (falling edge).
- ee = i ^ q (either edge).
- Outputs are combinational from q and i. Immediately after reset, a high i reports pe=1.

Decomposition:
- Shared package: ack_id_t (ID_WIDTH logic vector) and the constant MAX_STAGES=15.
- Sub-module: edge_det, instantiated inside bus_ack_gen on i; its pe is used as the request-start qualifier equivalently to cnt==0.
- edge_det is also exported standalone for slaves.

Test Plan:
1. Read latency: READ_STAGES=2, REGISTER_OUTPUT=1; i=1, we_i=0 from cycle 0 and held → o=0 at cycles 0-2, o=1 from cycle 3; drop i at cycle 6 → o=0 at cycle 7.
2. Write latency: WRITE_STAGES=1, REGISTER_OUTPUT=1; i=1, we_i=1, wid_i=4'h5 → o=1 and wid_o=5 from cycle 2; rid_o stays 0 throughout.
3. Aborted request: READ_STAGES=3; i high for 2 cycles, then low → o never asserts. Re-assert i → o again after the full 3(+1) cycles.
4. Zero-latency combinational: WRITE_STAGES=0, REGISTER_OUTPUT=0; i=1, we_i=1 → o=1 in the same cycle; i=0 → o=0 in the same cycle.
5. ce_i and reset: ce_i=0 for 3 cycles mid-count → the acknowledge is delayed by exactly 3 cycles. Assert rst_i asynchronously while o=1 → o, rid_o and wid_o go to 0 immediately.
6. edge_det: i sequence 0,1,1,0,0 with ce=1 → pe=0,1,0,0,0; ne=0,0,0,1,0; ee=0,1,0,1,0. With ce=0 while i toggles 0→1 → pe stays 1 until ce returns.

Source files
------------

// File: rtl/bus_ack_gen_pkg.sv
// Shared types and constants for the bus acknowledge generator.
package bus_ack_gen_pkg;

  localparam int         ID_WIDTH_DEF = 4;
  localparam logic [3:0] MAX_STAGES   = 4'd15;

  typedef logic [ID_WIDTH_DEF-1:0] ack_id_t;

  // Wait counter increment that sticks at the top so a long request never wraps.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == MAX_STAGES) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/bus_ack_gen_edge_det.sv
// Single-bit edge detector: one history flop, combinational edge flags.
module edge_det
  import bus_ack_gen_pkg::*;
(
  input  logic rst,
  input  logic clk,
  input  logic ce,
  input  logic i,
  output logic pe,
  output logic ne,
  output logic ee
);

  logic q;

  // History flop follows the input only on enabled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= 1'b0;
    else if (ce) q <= i;
  end

  assign pe = i & ~q;
  assign ne = ~i & q;
  assign ee = i ^ q;

endmodule

// File: rtl/bus_ack_gen.sv
// Bus-slave acknowledge generator with separate read/write wait states.
module bus_ack_gen
  import bus_ack_gen_pkg::*;
#(
  parameter int unsigned READ_STAGES     = 3,
  parameter int unsigned WRITE_STAGES    = 0,
  parameter int unsigned REGISTER_OUTPUT = 0,
  parameter int unsigned ID_WIDTH        = ID_WIDTH_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ce_i,
  input  logic                i,
  input  logic                we_i,
  input  logic [ID_WIDTH-1:0] rid_i,
  input  logic [ID_WIDTH-1:0] wid_i,
  output logic                o,
  output logic [ID_WIDTH-1:0] rid_o,
  output logic [ID_WIDTH-1:0] wid_o
);

  localparam logic [3:0] RD_LAT = 4'(READ_STAGES);
  localparam logic [3:0] WR_LAT = 4'(WRITE_STAGES);

  logic [3:0]          cnt;
  logic [ID_WIDTH-1:0] rid_q, wid_q;
  logic                we_q;
  logic                start, stop, edge_any;
  logic                typ_w, ack_raw;
  logic [ID_WIDTH-1:0] rid_c, wid_c;

  // Request start is the rising edge of i, which coincides with cnt==0 while i is high.
  edge_det u_req_edge (
    .rst (rst_i),
    .clk (clk_i),
    .ce  (ce_i),
    .i   (i),
    .pe  (start),
    .ne  (stop),
    .ee  (edge_any)
  );

  // Wait-state counter: clears while idle, saturates during long requests.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     cnt <= '0;
    else if (ce_i) cnt <= i ? sat_inc(cnt) : 4'd0;
  end

  // Capture type and IDs at request start; clear them when the request ends.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rid_q <= '0;
      wid_q <= '0;
      we_q  <= 1'b0;
    end else if (ce_i && edge_any) begin
      if (stop) begin
        rid_q <= '0;
        wid_q <= '0;
        we_q  <= 1'b0;
      end else begin
        rid_q <= rid_i;
        wid_q <= wid_i;
        we_q  <= we_i;
      end
    end
  end

  // Raw acknowledge and ID steering; in the start cycle the live inputs stand in for the latches.
  always_comb begin
    typ_w   = start ? we_i : we_q;
    ack_raw = ~rst_i & i & (typ_w ? (cnt >= WR_LAT) : (cnt >= RD_LAT));
    rid_c   = '0;
    wid_c   = '0;
    if (ack_raw && !typ_w) rid_c = start ? rid_i : rid_q;
    if (ack_raw &&  typ_w) wid_c = start ? wid_i : wid_q;
  end

  generate
    if (REGISTER_OUTPUT != 0) begin : g_reg
      // Optional output stage; holds with the rest of the state when ce_i is low.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          o     <= 1'b0;
          rid_o <= '0;
          wid_o <= '0;
        end else if (ce_i) begin
          o     <= ack_raw;
          rid_o <= rid_c;
          wid_o <= wid_c;
        end
      end
    end else begin : g_comb
      assign o     = ack_raw;
      assign rid_o = rid_c;
      assign wid_o = wid_c;
    end
  endgenerate

endmodule

// File: tb/tb_bus_ack_gen.sv
// Directed bench for bus_ack_gen (registered and combinational builds) and edge_det.
module tb_bus_ack_gen;
  import bus_ack_gen_pkg::*;

  typedef struct packed {
    logic       o_r;
    logic [3:0] rid_r;
    logic [3:0] wid_r;
    logic       o_c;
    logic [3:0] rid_c;
    logic [3:0] wid_c;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst, ce, i, we;
  ack_id_t rid, wid;
  logic    o_r, o_c;
  ack_id_t rid_r, wid_r, rid_c, wid_c;
  logic    ed_i, ed_ce, pe, ne, ee;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   step_no = 0;
  exp_t sb[$];
  logic [2:0] edq[$];

  always #5 clk = ~clk;

  bus_ack_gen #(.READ_STAGES(2), .WRITE_STAGES(1), .REGISTER_OUTPUT(1), .ID_WIDTH(4)) dut_r (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .i(i), .we_i(we), .rid_i(rid), .wid_i(wid),
    .o(o_r), .rid_o(rid_r), .wid_o(wid_r)
  );

  bus_ack_gen #(.READ_STAGES(3), .WRITE_STAGES(0), .REGISTER_OUTPUT(0), .ID_WIDTH(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .i(i), .we_i(we), .rid_i(rid), .wid_i(wid),
    .o(o_c), .rid_o(rid_c), .wid_o(wid_c)
  );

  edge_det u_ed (.rst(rst), .clk(clk), .ce(ed_ce), .i(ed_i), .pe(pe), .ne(ne), .ee(ee));

  function automatic exp_t mk(input logic a_o, input logic [3:0] a_r, a_w,
                              input logic b_o, input logic [3:0] b_r, b_w);
    return '{a_o, a_r, a_w, b_o, b_r, b_w};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, expv);
    end
  endtask

  task automatic chk_bus();
    exp_t x;
    x = sb.pop_front();
    chk("o_reg",   {3'b0, o_r}, {3'b0, x.o_r});
    chk("rid_reg", rid_r,       x.rid_r);
    chk("wid_reg", wid_r,       x.wid_r);
    chk("o_comb",  {3'b0, o_c}, {3'b0, x.o_c});
    chk("rid_comb", rid_c,      x.rid_c);
    chk("wid_comb", wid_c,      x.wid_c);
  endtask

  // Drive one cycle of bus inputs just after the edge, check mid-cycle.
  task automatic step(input logic rs, c, ii, w, input logic [3:0] r, wd, input exp_t e);
    @(posedge clk); #1;
    step_no++;
    rst = rs; ce = c; i = ii; we = w; rid = r; wid = wd;
    sb.push_back(e);
    @(negedge clk);
    chk_bus();
  endtask

  task automatic ed_step(input logic rs, c, ii, input logic epe, ene, eee);
    logic [2:0] x;
    @(posedge clk); #1;
    step_no++;
    rst = rs; ed_ce = c; ed_i = ii;
    edq.push_back({epe, ene, eee});
    @(negedge clk);
    x = edq.pop_front();
    chk("pe", {3'b0, pe}, {3'b0, x[2]});
    chk("ne", {3'b0, ne}, {3'b0, x[1]});
    chk("ee", {3'b0, ee}, {3'b0, x[0]});
  endtask

  initial begin
    exp_t z;
    z = mk(0, 0, 0, 0, 0, 0);
    rst = 1'b1; ce = 1'b1; i = 1'b0; we = 1'b0; rid = 4'hA; wid = 4'h5;
    ed_i = 1'b0; ed_ce = 1'b1;

    // Reset held with a zero-latency write pending: everything reads 0.
    step(1, 1, 1, 1, 4'hA, 4'h5, z);
    step(0, 1, 0, 0, 4'hA, 4'h5, z);

    // Read latency; rid_i changes mid-request but the latched ID is returned.
    step(0, 1, 1, 0, 4'hA, 4'h5, z);
    step(0, 1, 1, 0, 4'hA, 4'h5, z);
    step(0, 1, 1, 0, 4'hA, 4'h5, z);
    step(0, 1, 1, 0, 4'hA, 4'h5, mk(1, 4'hA, 0, 1, 4'hA, 0));
    step(0, 1, 1, 0, 4'h3, 4'h5, mk(1, 4'hA, 0, 1, 4'hA, 0));
    step(0, 1, 1, 0, 4'h3, 4'h5, mk(1, 4'hA, 0, 1, 4'hA, 0));
    step(0, 1, 0, 0, 4'hA, 4'h5, mk(1, 4'hA, 0, 0, 0, 0));
    step(0, 1, 0, 0, 4'hA, 4'h5, z);

    // Write latency; combinational build acks in the same cycle; we_i flip mid-request is ignored.
    step(0, 1, 1, 1, 4'hA, 4'h5, mk(0, 0, 0, 1, 0, 4'h5));
    step(0, 1, 1, 1, 4'hA, 4'h5, mk(0, 0, 0, 1, 0, 4'h5));
    step(0, 1, 1, 0, 4'hA, 4'h5, mk(1, 0, 4'h5, 1, 0, 4'h5));
    step(0, 1, 0, 0, 4'hA, 4'h5, mk(1, 0, 4'h5, 0, 0, 0));
    step(0, 1, 0, 0, 4'hA, 4'h5, z);

    // Aborted read, then a fresh full-length read.
    step(0, 1, 1, 0, 4'hC, 4'h5, z);
    step(0, 1, 1, 0, 4'hC, 4'h5, z);
    step(0, 1, 0, 0, 4'hC, 4'h5, z);
    step(0, 1, 1, 0, 4'hC, 4'h5, z);
    step(0, 1, 1, 0, 4'hC, 4'h5, z);
    step(0, 1, 1, 0, 4'hC, 4'h5, z);
    step(0, 1, 1, 0, 4'hC, 4'h5, mk(1, 4'hC, 0, 1, 4'hC, 0));
    step(0, 1, 0, 0, 4'hC, 4'h5, mk(1, 4'hC, 0, 0, 0, 0));
    step(0, 1, 0, 0, 4'hC, 4'h5, z);

    // Three ce-low cycles mid-count push the ack out by three cycles.
    step(0, 1, 1, 0, 4'hA, 4'h5, z);
    step(0, 1, 1, 0, 4'hA, 4'h5, z);
    step(0, 0, 1, 0, 4'hA, 4'h5, z);
    step(0, 0, 1, 0, 4'hA, 4'h5, z);
    step(0, 0, 1, 0, 4'hA, 4'h5, z);
    step(0, 1, 1, 0, 4'hA, 4'h5, z);
    step(0, 1, 1, 0, 4'hA, 4'h5, mk(1, 4'hA, 0, 1, 4'hA, 0));

    // Asynchronous reset while acknowledging clears outputs before any edge.
    sb.push_back(z);
    #2 rst = 1'b1;
    #1 chk_bus();
    step(1, 1, 0, 0, 4'hA, 4'h5, z);
    step(0, 1, 0, 0, 4'hA, 4'h5, z);

    // edge_det: high input straight out of reset, then 0,1,1,0,0, then a stalled rise.
    ed_step(1, 1, 1, 1, 0, 1);
    ed_step(0, 1, 0, 0, 0, 0);
    ed_step(0, 1, 0, 0, 0, 0);
    ed_step(0, 1, 1, 1, 0, 1);
    ed_step(0, 1, 1, 0, 0, 0);
    ed_step(0, 1, 0, 0, 1, 1);
    ed_step(0, 1, 0, 0, 0, 0);
    ed_step(0, 0, 1, 1, 0, 1);
    ed_step(0, 0, 1, 1, 0, 1);
    ed_step(0, 1, 1, 1, 0, 1);
    ed_step(0, 1, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
